// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    ABORT = 3'd4
  } state_e;

  localparam int         CMD_RW_BIT = 7;
  localparam logic [7:0] TX_IDLE    = 8'h00;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with edge detection
// on the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI register-access controller: frames bytes from synchronised SCK/CS,
// decodes the command byte and runs auto-incrementing register bursts.
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCK,
  input  logic              CS,
  input  logic [7:0]        RX_BYTE,
  output logic [7:0]        TX_BYTE,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [7:0]        REG_WDATA,
  output logic              REG_WE,
  output logic              REG_RE,
  input  logic [7:0]        REG_RDATA,
  output logic              BUSY,
  output logic              FRAME_ERR
);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic sck_unused_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .CLK(CLK), .RST(RST), .din(SCK), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  // CS resets to "selected" so a reset inside a frame cannot fake a new cs_fall.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .CLK(CLK), .RST(RST), .din(CS), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  assign sck_unused_s = sck_lvl ^ sck_rise;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              busy_q, busy_d;
  logic              ferr_q, ferr_d;
  logic              inc_q, inc_d;
  logic              rdpend_q, rdpend_d;
  logic              count_en, byte_done;

  assign count_en  = sck_fall & ~cs_lvl & ~cs_rise;
  assign byte_done = count_en & (cnt_q == 3'd7);

  always_comb begin
    cnt_d = cnt_q;
    if (cs_fall) begin
      cnt_d = 3'd0;
    end else if (count_en) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    busy_d   = busy_q;
    ferr_d   = 1'b0;
    inc_d    = 1'b0;
    rdpend_d = re_q;

    // Post-write increment and read-data capture land one cycle after their strobe.
    if (inc_q) begin
      addr_d = addr_q + 1'b1;
    end else begin
      addr_d = addr_q;
    end
    if (rdpend_q && (state_q == RDATA)) begin
      tx_d = REG_RDATA;
    end else begin
      tx_d = tx_q;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          busy_d  = 1'b1;
          tx_d    = TX_IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      CMD, WDATA, RDATA: begin
        if (cs_rise) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          tx_d    = TX_IDLE;
          ferr_d  = (cnt_q != 3'd0);
        end else if (byte_done) begin
          if (state_q == CMD) begin
            addr_d = RX_BYTE[ADDR_W-1:0];
            if (RX_BYTE[CMD_RW_BIT]) begin
              re_d    = 1'b1;
              state_d = RDATA;
            end else begin
              state_d = WDATA;
            end
          end else if (state_q == WDATA) begin
            wdata_d = RX_BYTE;
            we_d    = 1'b1;
            inc_d   = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
            re_d   = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ABORT: begin
        if (cs_lvl) begin
          state_d = IDLE;
        end else begin
          state_d = ABORT;
        end
      end
      default: begin
        state_d = ABORT;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ABORT;
      cnt_q    <= 3'd0;
      tx_q     <= TX_IDLE;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      inc_q    <= 1'b0;
      rdpend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      busy_q   <= busy_d;
      ferr_q   <= ferr_d;
      inc_q    <= inc_d;
      rdpend_q <= rdpend_d;
    end
  end

  assign TX_BYTE   = tx_q;
  assign REG_ADDR  = addr_q;
  assign REG_WDATA = wdata_q;
  assign REG_WE    = we_q;
  assign REG_RE    = re_q;
  assign BUSY      = busy_q;
  assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: acts as the SCK-domain shifter and a
// register file, scoreboarding every REG_WE/REG_RE strobe.
module tb_spi_reg_ctrl;
  import spi_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SCK = 1'b0;
  logic       CS  = 1'b1;
  logic [7:0] RX_BYTE = 8'h00;
  logic [7:0] TX_BYTE;
  logic [3:0] REG_ADDR;
  logic [7:0] REG_WDATA;
  logic       REG_WE, REG_RE;
  logic [7:0] REG_RDATA;
  logic       BUSY, FRAME_ERR;

  spi_reg_ctrl #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .SCK(SCK), .CS(CS), .RX_BYTE(RX_BYTE), .TX_BYTE(TX_BYTE),
    .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA), .REG_WE(REG_WE), .REG_RE(REG_RE),
    .REG_RDATA(REG_RDATA), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] mem [16];
  int         errors = 0;
  int         checks = 0;
  int         ferr_cnt = 0;
  int         ferr_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register file read port: data valid the cycle after REG_RE.
  always @(posedge CLK) begin
    if (REG_RE) REG_RDATA <= mem[REG_ADDR];
  end

  // Strobe scoreboard and FRAME_ERR pulse counter, sampled mid-cycle.
  always @(negedge CLK) begin
    ev_t e;
    if (REG_WE || REG_RE) begin
      check("we_re_exclusive", {31'd0, REG_WE & REG_RE}, 32'd0);
      check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("strobe_kind", {31'd0, REG_WE}, {31'd0, e.we});
        check("strobe_addr", {28'd0, REG_ADDR}, {28'd0, e.addr});
        if (e.we) check("strobe_wdata", {24'd0, REG_WDATA}, {24'd0, e.data});
      end
    end
    if (FRAME_ERR) ferr_cnt++;
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic sck_bit();
    SCK = 1'b1; clk_n(10);
    SCK = 1'b0; clk_n(10);
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_BYTE = b;
    repeat (8) sck_bit();
  endtask

  task automatic cs_start();
    CS = 1'b0; clk_n(10);
  endtask

  task automatic cs_end();
    CS = 1'b1; clk_n(10);
  endtask

  task automatic push(input logic we, input logic [3:0] addr, input logic [7:0] data);
    ev_t e;
    e.we = we; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"},    {24'd0, TX_BYTE},   32'h00);
    check({tag, "_addr"},  {28'd0, REG_ADDR},  32'h0);
    check({tag, "_wdata"}, {24'd0, REG_WDATA}, 32'h00);
    check({tag, "_we"},    {31'd0, REG_WE},    32'd0);
    check({tag, "_re"},    {31'd0, REG_RE},    32'd0);
    check({tag, "_busy"},  {31'd0, BUSY},      32'd0);
    check({tag, "_ferr"},  {31'd0, FRAME_ERR}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[2] = 8'h3C;
    mem[3] = 8'hC3;

    // Reset state
    clk_n(3);
    check_reset_outputs("reset");
    RST = 1'b0;
    clk_n(10);
    check("idle_after_reset", {29'd0, dut.state_q}, {29'd0, IDLE});

    // Single write 0x03 <- 0x5A
    push(1'b1, 4'd3, 8'h5A);
    cs_start();
    check("busy_in_frame", {31'd0, BUSY}, 32'd1);
    check("tx_idle_in_frame", {24'd0, TX_BYTE}, 32'h00);
    send_byte(8'h03);
    send_byte(8'h5A);
    cs_end();
    check("wr_busy_end", {31'd0, BUSY}, 32'd0);
    check("wr_ferr_none", ferr_cnt, 32'd0);
    check("wr_wdata", {24'd0, REG_WDATA}, 32'h5A);
    check("wr_consumed", exp_q.size(), 32'd0);

    // Burst write wrapping 15 -> 0
    push(1'b1, 4'd15, 8'h11);
    push(1'b1, 4'd0, 8'h22);
    cs_start();
    send_byte(8'h0F);
    send_byte(8'h11);
    send_byte(8'h22);
    cs_end();
    check("burst_wr_consumed", exp_q.size(), 32'd0);

    // Read burst from 2; each byte_done prefetches the next address
    push(1'b0, 4'd2, 8'h00);
    push(1'b0, 4'd3, 8'h00);
    push(1'b0, 4'd4, 8'h00);
    cs_start();
    send_byte(8'h82);
    check("rd_tx_first", {24'd0, TX_BYTE}, 32'h3C);
    send_byte(8'h00);
    check("rd_tx_second", {24'd0, TX_BYTE}, 32'hC3);
    send_byte(8'h00);
    cs_end();
    check("rd_tx_after_end", {24'd0, TX_BYTE}, 32'h00);
    check("rd_consumed", exp_q.size(), 32'd0);

    // Abort mid-byte: 5 falls of the data byte
    ferr_base = ferr_cnt;
    cs_start();
    send_byte(8'h01);
    RX_BYTE = 8'hEE;
    repeat (5) sck_bit();
    cs_end();
    check("abort_ferr_once", ferr_cnt, ferr_base + 1);
    check("abort_state_idle", {29'd0, dut.state_q}, {29'd0, IDLE});
    check("abort_busy", {31'd0, BUSY}, 32'd0);

    // Reset after 12 falls of a write frame, then a clean frame
    cs_start();
    send_byte(8'h06);
    RX_BYTE = 8'h77;
    repeat (4) sck_bit();
    RST = 1'b1;
    clk_n(1);
    check_reset_outputs("midrst");
    RST = 1'b0;
    repeat (4) sck_bit();
    send_byte(8'h88);
    check("midrst_busy", {31'd0, BUSY}, 32'd0);
    cs_end();
    push(1'b1, 4'd4, 8'h99);
    cs_start();
    send_byte(8'h04);
    send_byte(8'h99);
    cs_end();
    check("post_rst_consumed", exp_q.size(), 32'd0);
    check("post_rst_wdata", {24'd0, REG_WDATA}, 32'h99);

    // CS rise coincident with the 8th SCK fall of a data byte
    ferr_base = ferr_cnt;
    cs_start();
    send_byte(8'h05);
    RX_BYTE = 8'hAA;
    repeat (7) sck_bit();
    SCK = 1'b1; clk_n(10);
    SCK = 1'b0; CS = 1'b1;
    clk_n(10);
    check("coinc_ferr_once", ferr_cnt, ferr_base + 1);
    check("coinc_state_idle", {29'd0, dut.state_q}, {29'd0, IDLE});
    check("coinc_no_strobe", exp_q.size(), 32'd0);

    clk_n(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
